mem_bus_arbiter: RTL

- Shares the single SRAM-like memory bus between the IF-stage instruction fetch port and the MEM-stage load/store port.
- Sequences each transfer through an address phase and a data phase (addr_ok / data_ok handshake).
- Returns read data and a one-cycle done pulse to the owning port.
- Raises per-port stall requests that the pipeline stall controller folds into the stall bus.

---
 rtl/mem_bus_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like memory bus between the fetch port and the load/store port.
// Each transfer runs an address phase (addr_ok) and then a data phase (data_ok).
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_done,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_done,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                stallreq_inst,
    output logic                stallreq_data
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    typedef enum logic {OWN_INST, OWN_DATA} owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_wr_q, bus_wr_d;
    logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
    logic                inst_done_q, inst_done_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
    logic                data_done_q, data_done_d;
    logic                complete;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_INST;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_wstrb_q  <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            inst_rdata_q <= '0;
            inst_done_q  <= 1'b0;
            data_rdata_q <= '0;
            data_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            bus_req_q    <= bus_req_d;
            bus_wr_q     <= bus_wr_d;
            bus_wstrb_q  <= bus_wstrb_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            inst_done_q  <= inst_done_d;
            data_rdata_q <= data_rdata_d;
            data_done_q  <= data_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        bus_req_d    = bus_req_q;
        bus_wr_d     = bus_wr_q;
        bus_wstrb_d  = bus_wstrb_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        inst_rdata_d = inst_rdata_q;
        inst_done_d  = 1'b0;
        data_rdata_d = data_rdata_q;
        data_done_d  = 1'b0;
        complete     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A port pulsing done still holds its request; mask it so it is not re-granted.
                if (data_req && !data_done_q) begin
                    owner_d     = OWN_DATA;
                    bus_req_d   = 1'b1;
                    bus_wr_d    = data_wr;
                    bus_wstrb_d = data_wr ? data_wstrb : '0;
                    bus_addr_d  = data_addr;
                    bus_wdata_d = data_wdata;
                    state_d     = ADDR;
                end else if (inst_req && !inst_done_q) begin
                    owner_d     = OWN_INST;
                    bus_req_d   = 1'b1;
                    bus_wr_d    = 1'b0;
                    bus_wstrb_d = '0;
                    bus_addr_d  = inst_addr;
                    bus_wdata_d = '0;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    bus_req_d = 1'b0;
                    if (bus_data_ok) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d  = DATA;
                    end
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            if (owner_q == OWN_DATA) begin
                data_done_d  = 1'b1;
                data_rdata_d = bus_rdata;
            end else begin
                inst_done_d  = 1'b1;
                inst_rdata_d = bus_rdata;
            end
        end
    end

    assign bus_req       = bus_req_q;
    assign bus_wr        = bus_wr_q;
    assign bus_wstrb     = bus_wstrb_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wdata     = bus_wdata_q;
    assign inst_rdata    = inst_rdata_q;
    assign inst_done     = inst_done_q;
    assign data_rdata    = data_rdata_q;
    assign data_done     = data_done_q;
    assign stallreq_inst = inst_req & ~inst_done_q;
    assign stallreq_data = data_req & ~data_done_q;

endmodule
